// File: rtl/sha2_pkg.sv
// SHA-2 sigma function package: function select encoding, rotate/shift
// amount tables for SHA-256 and SHA-512, and the word-width legality check.
package sha2_pkg;

   typedef enum logic [1:0] {
      F_BSIG0 = 2'd0,
      F_BSIG1 = 2'd1,
      F_SSIG0 = 2'd2,
      F_SSIG1 = 2'd3
   } func_e;

   // Amounts per function, ordered term0, term1, term2.
   localparam int unsigned AMT32 [4][3] = '{
      '{ 2, 13, 22},
      '{ 6, 11, 25},
      '{ 7, 18,  3},
      '{17, 19, 10}
   };

   localparam int unsigned AMT64 [4][3] = '{
      '{28, 34, 39},
      '{14, 18, 41},
      '{ 1,  8,  7},
      '{19, 61,  6}
   };

   function automatic int unsigned sigma_amt(input int unsigned width, input func_e f,
                                             input logic [1:0] k);
      return (width == 64) ? AMT64[f][k] : AMT32[f][k];
   endfunction

   // The small sigmas use a logical shift (zero fill) for their third term.
   function automatic logic term2_is_shr(input func_e f);
      return (f == F_SSIG0) || (f == F_SSIG1);
   endfunction

   function automatic logic width_legal(input int unsigned w);
      return (w == 32) || (w == 64);
   endfunction

endpackage

// File: rtl/sha2_sigma_terms.sv
// Combinational generator of the three rotate/shift terms of a SHA-2 sigma
// function; the caller XORs them. Every amount is a constant, so each
// candidate is plain wiring and only the final 4:1 select costs logic.
module sha2_sigma_terms
   import sha2_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  func_e            func,
   output logic [WIDTH-1:0] term0,
   output logic [WIDTH-1:0] term1,
   output logic [WIDTH-1:0] term2
);

   logic [WIDTH-1:0] cand [4][3];

   for (genvar f = 0; f < 4; f++) begin : g_func
      for (genvar k = 0; k < 3; k++) begin : g_term
         localparam int unsigned AMT    = sigma_amt(WIDTH, func_e'(f), 2'(k));
         localparam logic        IS_SHR = (k == 2) && term2_is_shr(func_e'(f));
         if (IS_SHR) begin : g_shr
            assign cand[f][k] = data >> AMT;
         end else begin : g_rot
            assign cand[f][k] = (data >> AMT) | (data << (WIDTH - AMT));
         end
      end
   end

   // Pick the three terms of the requested function.
   always_comb begin
      term0 = cand[func][0];
      term1 = cand[func][1];
      term2 = cand[func][2];
   end

endmodule

// File: rtl/sha2_sigma_pipe.sv
// Pipelined SHA-2 sigma unit (Σ0/Σ1/σ0/σ1) with valid/ready handshake and a
// pass-through tag. One or two register stages; each stage accepts a new word
// when empty or when the stage after it is taking its current word.
module sha2_sigma_pipe
   import sha2_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned PIPE_STAGES = 2,
   parameter int unsigned TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_func,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   if (!width_legal(WIDTH)) begin : g_bad_width
      $error("sha2_sigma_pipe: WIDTH must be 32 or 64");
   end
   if ((PIPE_STAGES != 1) && (PIPE_STAGES != 2)) begin : g_bad_stages
      $error("sha2_sigma_pipe: PIPE_STAGES must be 1 or 2");
   end

   func_e            in_func_e;
   logic [WIDTH-1:0] term0, term1, term2;

   assign in_func_e = func_e'(in_func);

   sha2_sigma_terms #(.WIDTH(WIDTH)) u_terms (
      .data  (in_data),
      .func  (in_func_e),
      .term0 (term0),
      .term1 (term1),
      .term2 (term2)
   );

   if (PIPE_STAGES == 1) begin : g_one
      logic             s0_load;
      logic             s0_v_q, s0_v_d;
      logic [WIDTH-1:0] s0_data_q, s0_data_d;
      logic [TAG_W-1:0] s0_tag_q, s0_tag_d;

      // Single stage: rotate, XOR and register in one step.
      always_comb begin
         s0_load   = !s0_v_q || out_ready;
         s0_v_d    = s0_v_q;
         s0_data_d = s0_data_q;
         s0_tag_d  = s0_tag_q;
         if (s0_load) begin
            s0_v_d = in_valid;
            if (in_valid) begin
               s0_data_d = term0 ^ term1 ^ term2;
               s0_tag_d  = in_tag;
            end
         end
      end

      // Stage register with asynchronous clear.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s0_v_q    <= 1'b0;
            s0_data_q <= '0;
            s0_tag_q  <= '0;
         end else begin
            s0_v_q    <= s0_v_d;
            s0_data_q <= s0_data_d;
            s0_tag_q  <= s0_tag_d;
         end
      end

      assign in_ready  = s0_load;
      assign out_valid = s0_v_q;
      assign out_data  = s0_data_q;
      assign out_tag   = s0_tag_q;
      assign busy      = s0_v_q;
   end else begin : g_two
      logic             s0_load, s1_load;
      logic             s0_v_q, s0_v_d;
      logic [WIDTH-1:0] s0_t0_q, s0_t0_d, s0_t1_q, s0_t1_d, s0_t2_q, s0_t2_d;
      logic [TAG_W-1:0] s0_tag_q, s0_tag_d;
      logic             s1_v_q, s1_v_d;
      logic [WIDTH-1:0] s1_data_q, s1_data_d;
      logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

      // Stage 0 registers the three terms; stage 1 XORs them. Ready ripples
      // back combinationally from out_ready so a full pipe still streams.
      always_comb begin
         s1_load   = !s1_v_q || out_ready;
         s0_load   = !s0_v_q || s1_load;
         s0_v_d    = s0_v_q;
         s0_t0_d   = s0_t0_q;
         s0_t1_d   = s0_t1_q;
         s0_t2_d   = s0_t2_q;
         s0_tag_d  = s0_tag_q;
         s1_v_d    = s1_v_q;
         s1_data_d = s1_data_q;
         s1_tag_d  = s1_tag_q;
         if (s1_load) begin
            s1_v_d = s0_v_q;
            if (s0_v_q) begin
               s1_data_d = s0_t0_q ^ s0_t1_q ^ s0_t2_q;
               s1_tag_d  = s0_tag_q;
            end
         end
         if (s0_load) begin
            s0_v_d = in_valid;
            if (in_valid) begin
               s0_t0_d  = term0;
               s0_t1_d  = term1;
               s0_t2_d  = term2;
               s0_tag_d = in_tag;
            end
         end
      end

      // Both stage registers with asynchronous clear.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s0_v_q    <= 1'b0;
            s0_t0_q   <= '0;
            s0_t1_q   <= '0;
            s0_t2_q   <= '0;
            s0_tag_q  <= '0;
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_tag_q  <= '0;
         end else begin
            s0_v_q    <= s0_v_d;
            s0_t0_q   <= s0_t0_d;
            s0_t1_q   <= s0_t1_d;
            s0_t2_q   <= s0_t2_d;
            s0_tag_q  <= s0_tag_d;
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_tag_q  <= s1_tag_d;
         end
      end

      assign in_ready  = s0_load;
      assign out_valid = s1_v_q;
      assign out_data  = s1_data_q;
      assign out_tag   = s1_tag_q;
      assign busy      = s0_v_q | s1_v_q;
   end

endmodule
